wb_arbiter_2m: RTL and testbench
================================

# wb_arbiter_2m

Two-master, single-slave Wishbone classic arbiter that shares the unified instruction/data memory between the RiscV_MultiCycle core (master 0) and a second bus master such as a debug loader or DMA engine (master 1). It holds a registered grant FSM with round-robin tie-breaking and bus locking for the duration of `cyc`. It also runs a per-transfer timeout watchdog that signals `err` to the granted master when the slave never acknowledges. It sits between the masters' Wishbone ports and the memory's slave port.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 255: number of un-acked strobe cycles before `err` is raised. Legal range 2..65535.

Ports:
- `wb_clk`  in  1  clock; all state updates on the rising edge.
- `wb_rst`  in  1  synchronous, active-high reset.
- `m0_adr_i` / `m1_adr_i`  in  32  master address.
- `m0_dat_i` / `m1_dat_i`  in  32  master write data.
- `m0_we_i` / `m1_we_i`  in  1  master write enable.
- `m0_cyc_i` / `m1_cyc_i`  in  1  master bus request and lock.
- `m0_stb_i` / `m1_stb_i`  in  1  master strobe.
- `m0_dat_o` / `m1_dat_o`  out  32  read data; `s_dat_i` broadcast to both masters.
- `m0_ack_o` / `m1_ack_o`  out  1  acknowledge, routed to the granted master only.
- `m0_err_o` / `m1_err_o`  out  1  timeout error pulse, routed to the granted master only.
- `s_adr_o`  out  32  slave address.
- `s_dat_o`  out  32  slave write data.
- `s_we_o`  out  1  slave write enable.
- `s_cyc_o`  out  1  slave cycle.
- `s_stb_o`  out  1  slave strobe.
- `s_dat_i`  in  32  slave read data.
- `s_ack_i`  in  1  slave acknowledge.
- `gnt_o`  out  2  one-hot grant status: bit0 = M0, bit1 = M1, 00 = idle.

## Operation
- States: IDLE, GNT0, GNT1. The state is registered. `gnt_o` decodes the state.
- Round-robin register `last` (0 = M0, 1 = M1) records the most recently granted master. Reset value is 1, so M0 wins the first tie.
- IDLE:
  - Only `m0_cyc_i` high → GNT0.
  - Only `m1_cyc_i` high → GNT1.
  - Both high → grant goes to the master ≠ `last`.
  - Neither high → stay in IDLE.
- GNTx while `mx_cyc_i` is high: stay in GNTx. The bus is locked, whatever the other master does.
- GNTx when `mx_cyc_i` is low:
  - Other master's `cyc` high → go directly to the other GNT state (no idle cycle).
  - Otherwise → IDLE.
- `last` updates to x on every entry to GNTx.
- Slave-side mux is combinational from the state:
  - In GNTx, `s_adr/dat/we/cyc/stb` follow master x.
  - In IDLE, all slave outputs are 0.
  - `s_cyc_o` is additionally gated by `mx_cyc_i`.
- Acknowledge routing: `mx_ack_o = s_ack_i & (state==GNTx)`. The non-granted master's ack and err are always 0.
- Timeout counter `tcnt`:
  - Width is ceil(log2(TIMEOUT_CYCLES+1)).
  - Clears on `s_ack_i`, on a state change, or when `s_stb_o` is low.
  - Otherwise it increments each cycle `s_stb_o` is high.
- Error pulse:
  - When `tcnt == TIMEOUT_CYCLES-1` and `s_ack_i` is low, a registered `err_q` is set for exactly one cycle.
  - `err_q` drives `mx_err_o` of the granted master.
  - During that cycle `s_stb_o` is forced to 0 and `tcnt` clears.
- Simultaneous `s_ack_i` and timeout expiry: ack wins. No err is raised and the counter clears.
- After err the grant is kept. The master must drop `cyc`, and release then follows the normal rules.

## Timing
- Arbitration latency: 1 cycle. A master raising `cyc` at edge N sees its signals on the slave port from cycle N+1 (the earliest cycle `gnt_o` shows the grant).
- Handoff: the granted master drops `cyc` while the other requests. The other master's signals appear on the slave port the next cycle, with zero idle cycles.
- Ack and data path: combinational, 0 cycles from `s_ack_i` to `mx_ack_o`.
- Err timing: asserted on the cycle after `TIMEOUT_CYCLES` consecutive strobed cycles without ack, i.e. strobe presented on cycles 1..T, err high on cycle T+1.
- Reset (including mid-transfer), at the first edge with `wb_rst` high:
  - State = IDLE, `last` = 1, `tcnt` = 0, `err_q` = 0.
  - All slave outputs, acks, errs and `gnt_o` read 0 from that cycle on.
  - An in-flight slave ack arriving during reset is dropped.

## Test plan
- Single master: M0 raises `cyc`/`stb` to read addr 0x0000_0010, slave acks with 0xDEAD_BEEF on its 2nd cycle. Required: `gnt_o`=01 one cycle after request; `m0_ack_o` pulses with `m0_dat_o`=0xDEAD_BEEF; `m1_ack_o` stays 0.
- Tie after reset: both `cyc` rise in the same cycle. Required: M0 granted first. M0 drops `cyc` → M1 granted next cycle. Both then re-request → M0 wins again (alternation over 4 rounds: 0,1,0,1).
- Lock: M1 holds `cyc` across 3 writes (addr 0x100, 0x104, 0x108) while M0 requests throughout. Required: M0 never sees the slave port until the cycle after M1 drops `cyc`; `s_we_o`=1 for all 3 beats.
- Timeout with `TIMEOUT_CYCLES`=4: M0 strobes and the slave never acks. Required: `m0_err_o` high for exactly one cycle on cycle 5; `s_stb_o`=0 in that cycle; no ack. Repeat with ack on cycle 4: no err.
- Reset mid-op: assert `wb_rst` while GNT1 is strobing, with `s_ack_i` high in the same cycle. Required: next cycle `gnt_o`=00, `m1_ack_o`=0, and all `s_*` outputs 0. After release with both requesting, M0 is granted.

Source files
------------

// File: rtl/wb_arbiter_2m.sv
`default_nettype none
// ============================================================================
// Module      : wb_arbiter_2m
// Description : Two-master Wishbone classic arbiter with round-robin tie
//               break, cyc-based bus lock and per-transfer timeout error.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_arbiter_2m #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        wb_clk,
    input  logic        wb_rst,
    input  logic [31:0] m0_adr_i,
    input  logic [31:0] m0_dat_i,
    input  logic        m0_we_i,
    input  logic        m0_cyc_i,
    input  logic        m0_stb_i,
    output logic [31:0] m0_dat_o,
    output logic        m0_ack_o,
    output logic        m0_err_o,
    input  logic [31:0] m1_adr_i,
    input  logic [31:0] m1_dat_i,
    input  logic        m1_we_i,
    input  logic        m1_cyc_i,
    input  logic        m1_stb_i,
    output logic [31:0] m1_dat_o,
    output logic        m1_ack_o,
    output logic        m1_err_o,
    output logic [31:0] s_adr_o,
    output logic [31:0] s_dat_o,
    output logic        s_we_o,
    output logic        s_cyc_o,
    output logic        s_stb_o,
    input  logic [31:0] s_dat_i,
    input  logic        s_ack_i,
    output logic [1:0]  gnt_o
);

    localparam int unsigned       c_TW    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [c_TW-1:0]   c_TLIM  = c_TW'(TIMEOUT_CYCLES - 1);
    localparam logic [c_TW-1:0]   c_ONE   = c_TW'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_GNT0 = 2'd1,
        S_GNT1 = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_next;
    logic            r_last;
    logic            r_err;
    logic [c_TW-1:0] r_tcnt;
    logic [1:0]      r_gnt;
    logic            w_stb;
    logic            w_chg;
    logic            w_timeout;
    logic            w_tclr;

    // A granted master keeps the bus while its cyc is high; on release the
    // other requester takes over directly without an idle cycle.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (m0_cyc_i && m1_cyc_i)
                    w_next = r_last ? S_GNT0 : S_GNT1;
                else if (m0_cyc_i)
                    w_next = S_GNT0;
                else if (m1_cyc_i)
                    w_next = S_GNT1;
            end
            S_GNT0: if (!m0_cyc_i) w_next = m1_cyc_i ? S_GNT1 : S_IDLE;
            S_GNT1: if (!m1_cyc_i) w_next = m0_cyc_i ? S_GNT0 : S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        s_adr_o = 32'd0;
        s_dat_o = 32'd0;
        s_we_o  = 1'b0;
        s_cyc_o = 1'b0;
        w_stb   = 1'b0;
        case (r_state)
            S_GNT0: begin
                s_adr_o = m0_adr_i;
                s_dat_o = m0_dat_i;
                s_we_o  = m0_we_i;
                s_cyc_o = m0_cyc_i;
                w_stb   = m0_stb_i;
            end
            S_GNT1: begin
                s_adr_o = m1_adr_i;
                s_dat_o = m1_dat_i;
                s_we_o  = m1_we_i;
                s_cyc_o = m1_cyc_i;
                w_stb   = m1_stb_i;
            end
            default: ;
        endcase
    end

    // The error cycle suppresses the strobe so the slave sees the transfer end.
    assign s_stb_o   = w_stb & ~r_err;
    assign w_chg     = (w_next != r_state);
    assign w_timeout = s_stb_o & ~s_ack_i & ~w_chg & (r_tcnt == c_TLIM);
    assign w_tclr    = s_ack_i | w_chg | ~s_stb_o | w_timeout;

    always_ff @(posedge wb_clk) begin
        if (wb_rst) begin
            r_state <= S_IDLE;
            r_last  <= 1'b1;
            r_tcnt  <= '0;
            r_err   <= 1'b0;
            r_gnt   <= 2'b00;
        end else begin
            r_state <= w_next;
            r_err   <= w_timeout;
            r_tcnt  <= w_tclr ? '0 : (r_tcnt + c_ONE);
            case (w_next)
                S_GNT0: begin
                    r_gnt  <= 2'b01;
                    r_last <= 1'b0;
                end
                S_GNT1: begin
                    r_gnt  <= 2'b10;
                    r_last <= 1'b1;
                end
                default: r_gnt <= 2'b00;
            endcase
        end
    end

    assign gnt_o    = r_gnt;
    assign m0_dat_o = s_dat_i;
    assign m1_dat_o = s_dat_i;
    assign m0_ack_o = s_ack_i & (r_state == S_GNT0);
    assign m1_ack_o = s_ack_i & (r_state == S_GNT1);
    assign m0_err_o = r_err & (r_state == S_GNT0);
    assign m1_err_o = r_err & (r_state == S_GNT1);

endmodule
`default_nettype wire

// File: tb/tb_wb_arbiter_2m.sv
`default_nettype none
// ============================================================================
// Module      : tb_wb_arbiter_2m
// Description : Table-driven self-checking bench for wb_arbiter_2m.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wb_arbiter_2m;

    localparam int unsigned c_T     = 4;
    localparam logic [31:0] c_M0DAT = 32'h0000_AAAA;
    localparam logic [31:0] c_M1DAT = 32'h0000_BBBB;

    logic        wb_clk = 1'b0;
    logic        wb_rst;
    logic [31:0] m0_adr_i, m1_adr_i, m0_dat_i, m1_dat_i;
    logic        m0_we_i, m0_cyc_i, m0_stb_i, m1_we_i, m1_cyc_i, m1_stb_i;
    logic [31:0] m0_dat_o, m1_dat_o, s_adr_o, s_dat_o, s_dat_i;
    logic        m0_ack_o, m0_err_o, m1_ack_o, m1_err_o;
    logic        s_we_o, s_cyc_o, s_stb_o, s_ack_i;
    logic [1:0]  gnt_o;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 wb_clk = ~wb_clk;

    wb_arbiter_2m #(.TIMEOUT_CYCLES(c_T)) dut (
        .wb_clk(wb_clk), .wb_rst(wb_rst),
        .m0_adr_i(m0_adr_i), .m0_dat_i(m0_dat_i), .m0_we_i(m0_we_i),
        .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i), .m0_dat_o(m0_dat_o),
        .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o),
        .m1_adr_i(m1_adr_i), .m1_dat_i(m1_dat_i), .m1_we_i(m1_we_i),
        .m1_cyc_i(m1_cyc_i), .m1_stb_i(m1_stb_i), .m1_dat_o(m1_dat_o),
        .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o),
        .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_we_o(s_we_o),
        .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_dat_i(s_dat_i),
        .s_ack_i(s_ack_i), .gnt_o(gnt_o)
    );

    // One record per clock cycle.
    // in  = {rst, m0 cyc/stb/we, m1 cyc/stb/we, s_ack}
    // exp = {gnt[1:0], s_cyc, s_stb, s_we, m0_ack, m1_ack, m0_err, m1_err}
    typedef struct {
        logic [7:0]  in;
        logic [31:0] a0;
        logic [31:0] a1;
        logic [31:0] sdat;
        logic [8:0]  exp;
        logic [31:0] eadr;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic [7:0] in, input logic [31:0] a0, input logic [31:0] a1,
                       input logic [31:0] sdat, input logic [8:0] exp, input logic [31:0] eadr);
        vec_t v;
        v.in = in; v.a0 = a0; v.a1 = a1; v.sdat = sdat; v.exp = exp; v.eadr = eadr;
        tbl.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, req);
        end
    endtask

    task automatic drive(input logic [7:0] in, input logic [31:0] a0, input logic [31:0] a1,
                         input logic [31:0] sdat);
        {wb_rst, m0_cyc_i, m0_stb_i, m0_we_i, m1_cyc_i, m1_stb_i, m1_we_i, s_ack_i} = in;
        m0_adr_i = a0;
        m1_adr_i = a1;
        s_dat_i  = sdat;
    endtask

    function automatic logic [31:0] act_bits();
        return {23'd0, gnt_o, s_cyc_o, s_stb_o, s_we_o, m0_ack_o, m1_ack_o, m0_err_o, m1_err_o};
    endfunction

    logic [31:0] exp_sdat;

    initial begin
        m0_dat_i = c_M0DAT;
        m1_dat_i = c_M1DAT;
        drive(8'b1_000_000_0, 32'd0, 32'd0, 32'd0);
        repeat (2) @(posedge wb_clk);

        // reset state
        add(8'b1_000_000_0, 32'h00, 32'h00, 32'd0,          9'b00_000_00_00, 32'h0);
        // single master read, ack on the slave's 2nd cycle
        add(8'b0_110_000_0, 32'h10, 32'h00, 32'd0,          9'b00_000_00_00, 32'h0);
        add(8'b0_110_000_0, 32'h10, 32'h00, 32'd0,          9'b01_110_00_00, 32'h10);
        add(8'b0_110_000_1, 32'h10, 32'h00, 32'hDEAD_BEEF,  9'b01_110_10_00, 32'h10);
        add(8'b0_000_000_0, 32'h10, 32'h00, 32'd0,          9'b01_000_00_00, 32'h10);
        add(8'b0_000_000_0, 32'h00, 32'h00, 32'd0,          9'b00_000_00_00, 32'h0);
        // tie rounds after reset: 0,1,0,1
        add(8'b1_000_000_0, 32'h00, 32'h00, 32'd0,          9'b00_000_00_00, 32'h0);
        for (int r = 0; r < 4; r++) begin
            add(8'b0_110_110_0, 32'h20, 32'h30, 32'd0,      9'b00_000_00_00, 32'h0);
            if (r % 2 == 0) begin
                add(8'b0_110_110_1, 32'h20, 32'h30, 32'hCAFE_0001, 9'b01_110_10_00, 32'h20);
                add(8'b0_000_000_0, 32'h20, 32'h30, 32'd0,        9'b01_000_00_00, 32'h20);
            end else begin
                add(8'b0_110_110_1, 32'h20, 32'h30, 32'hCAFE_0002, 9'b10_110_01_00, 32'h30);
                add(8'b0_000_000_0, 32'h20, 32'h30, 32'd0,        9'b10_000_00_00, 32'h30);
            end
        end
        add(8'b0_000_000_0, 32'h00, 32'h00, 32'd0,          9'b00_000_00_00, 32'h0);
        // lock: M1 writes three beats while M0 keeps requesting
        add(8'b0_000_111_0, 32'h40, 32'h100, 32'd0,         9'b00_000_00_00, 32'h0);
        add(8'b0_110_111_1, 32'h40, 32'h100, 32'h1,         9'b10_111_01_00, 32'h100);
        add(8'b0_110_111_1, 32'h40, 32'h104, 32'h2,         9'b10_111_01_00, 32'h104);
        add(8'b0_110_111_1, 32'h40, 32'h108, 32'h3,         9'b10_111_01_00, 32'h108);
        add(8'b0_110_000_0, 32'h40, 32'h108, 32'd0,         9'b10_000_00_00, 32'h108);
        add(8'b0_110_000_1, 32'h40, 32'h108, 32'h4,         9'b01_110_10_00, 32'h40);
        add(8'b0_000_000_0, 32'h40, 32'h108, 32'd0,         9'b01_000_00_00, 32'h40);
        add(8'b0_000_000_0, 32'h00, 32'h00, 32'd0,          9'b00_000_00_00, 32'h0);
        // timeout: strobe on cycles 1..4 without ack, err on cycle 5
        add(8'b0_110_000_0, 32'h50, 32'h00, 32'd0,          9'b00_000_00_00, 32'h0);
        for (int c = 0; c < 4; c++)
            add(8'b0_110_000_0, 32'h50, 32'h00, 32'd0,      9'b01_110_00_00, 32'h50);
        add(8'b0_110_000_0, 32'h50, 32'h00, 32'd0,          9'b01_100_00_10, 32'h50);
        add(8'b0_000_000_0, 32'h50, 32'h00, 32'd0,          9'b01_000_00_00, 32'h50);
        add(8'b0_000_000_0, 32'h00, 32'h00, 32'd0,          9'b00_000_00_00, 32'h0);
        // ack on cycle 4 coincides with expiry: ack wins, no err
        add(8'b0_110_000_0, 32'h54, 32'h00, 32'd0,          9'b00_000_00_00, 32'h0);
        for (int c = 0; c < 3; c++)
            add(8'b0_110_000_0, 32'h54, 32'h00, 32'd0,      9'b01_110_00_00, 32'h54);
        add(8'b0_110_000_1, 32'h54, 32'h00, 32'h1234_5678,  9'b01_110_10_00, 32'h54);
        add(8'b0_100_000_0, 32'h54, 32'h00, 32'd0,          9'b01_100_00_00, 32'h54);
        add(8'b0_000_000_0, 32'h54, 32'h00, 32'd0,          9'b01_000_00_00, 32'h54);
        add(8'b0_000_000_0, 32'h00, 32'h00, 32'd0,          9'b00_000_00_00, 32'h0);

        foreach (tbl[i]) begin
            @(negedge wb_clk);
            drive(tbl[i].in, tbl[i].a0, tbl[i].a1, tbl[i].sdat);
            #2;
            check($sformatf("row%0d ctl", i), act_bits(), {23'd0, tbl[i].exp});
            check($sformatf("row%0d s_adr", i), s_adr_o, tbl[i].eadr);
            exp_sdat = (tbl[i].exp[8:7] == 2'b01) ? c_M0DAT :
                       (tbl[i].exp[8:7] == 2'b10) ? c_M1DAT : 32'd0;
            check($sformatf("row%0d s_dat", i), s_dat_o, exp_sdat);
            check($sformatf("row%0d m0_dat", i), m0_dat_o, tbl[i].sdat);
            check($sformatf("row%0d m1_dat", i), m1_dat_o, tbl[i].sdat);
        end

        // reset in the middle of an M1 strobe with an ack in flight
        @(negedge wb_clk); drive(8'b0_000_110_0, 32'h60, 32'h200, 32'd0);
        #2; check("rst_mid pre-gnt", {30'd0, gnt_o}, 32'd0);
        @(negedge wb_clk);
        #2; check("rst_mid gnt1", {30'd0, gnt_o}, 32'd2);
        @(negedge wb_clk); drive(8'b1_000_111_1, 32'h60, 32'h200, 32'h5555_5555);
        @(negedge wb_clk); drive(8'b1_110_111_1, 32'h60, 32'h200, 32'h5555_5555);
        #2;
        check("rst_mid ctl", act_bits(), 32'd0);
        check("rst_mid s_adr", s_adr_o, 32'd0);
        check("rst_mid s_dat", s_dat_o, 32'd0);
        @(negedge wb_clk); drive(8'b0_110_110_0, 32'h60, 32'h200, 32'd0);
        #2; check("rst_rel idle", {30'd0, gnt_o}, 32'd0);
        @(negedge wb_clk);
        #2;
        check("rst_rel gnt0", {30'd0, gnt_o}, 32'd1);
        check("rst_rel s_adr", s_adr_o, 32'h60);
        @(negedge wb_clk); drive(8'b0_000_000_0, 32'd0, 32'd0, 32'd0);
        @(negedge wb_clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
